// File: rtl/bcd_conv_sched_if.sv
// Bundle between the scheduler, its requesters and the shared bin2bcd converter.
// slave = scheduler side, master = requesters plus converter.
interface bcd_conv_sched_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req;
  logic [32*N_REQ-1:0] req_din;
  logic [N_REQ-1:0]    ack;
  logic                rsp_valid;
  logic [2:0]          rsp_id;
  logic [23:0]         rsp_bcd;
  logic                rsp_ovf;
  logic                rsp_err;
  logic                cv_en;
  logic [31:0]         cv_din;
  logic                cv_done;
  logic [23:0]         cv_dout;

  modport slave (
    input  req, req_din, cv_done, cv_dout,
    output ack, rsp_valid, rsp_id, rsp_bcd, rsp_ovf, rsp_err, cv_en, cv_din
  );

  modport master (
    output req, req_din, cv_done, cv_dout,
    input  ack, rsp_valid, rsp_id, rsp_bcd, rsp_ovf, rsp_err, cv_en, cv_din
  );
endinterface

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one bin2bcd converter among N_REQ requesters.
//   state | meaning
//   IDLE  | arbitrate; overflow goes straight to RESP, else start the converter
//   ISSUE | cv_en is high this cycle; load the watchdog
//   WAIT  | wait for cv_done or watchdog terminal count
//   RESP  | drive the response registers, ack visible in the following cycle
module bcd_conv_sched #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  bcd_conv_sched_if.slave  bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic [IW-1:0] last;
  logic [IW-1:0] op_id;
  logic [23:0]   bcd_r;
  logic          ovf_r;
  logic          err_r;
  logic [TW-1:0] timer;

  logic          grant_vld;
  logic [IW-1:0] grant_id;
  logic [IW-1:0] cand;
  logic [31:0]   grant_din;
  logic [31:0]   din_arr [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      din_arr[i] = bus.req_din[32*i +: 32];
    end
  end

  // Scan downward so the candidate closest to last+1 is the one that sticks.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = IW'((int'(last) + k) % N_REQ);
      if (bus.req[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
  end

  assign grant_din = din_arr[grant_id];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last          <= IW'(N_REQ - 1);
      op_id         <= '0;
      bcd_r         <= '0;
      ovf_r         <= 1'b0;
      err_r         <= 1'b0;
      timer         <= '0;
      bus.ack       <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_bcd   <= '0;
      bus.rsp_ovf   <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.cv_en     <= 1'b0;
      bus.cv_din    <= '0;
    end else begin
      bus.ack       <= '0;
      bus.rsp_valid <= 1'b0;
      bus.cv_en     <= 1'b0;
      case (state)
        IDLE: begin
          // The ack cycle is skipped: the served req has not dropped yet.
          if (grant_vld && !bus.rsp_valid) begin
            op_id <= grant_id;
            if (grant_din > 32'd999_999) begin
              bcd_r <= 24'h999999;
              ovf_r <= 1'b1;
              state <= RESP;
            end else begin
              bus.cv_en  <= 1'b1;
              bus.cv_din <= grant_din;
              state      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          // Terminal count lands the error response TIMEOUT+2 cycles after the request.
          timer <= TW'(TIMEOUT - 2);
          state <= WAIT;
        end
        WAIT: begin
          if (bus.cv_done) begin
            bcd_r <= bus.cv_dout;
            state <= RESP;
          end else if (timer == '0) begin
            bcd_r <= '0;
            err_r <= 1'b1;
            state <= RESP;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        RESP: begin
          bus.rsp_valid <= 1'b1;
          bus.ack       <= N_REQ'(1) << op_id;
          bus.rsp_id    <= 3'(op_id);
          bus.rsp_bcd   <= bcd_r;
          bus.rsp_ovf   <= ovf_r;
          bus.rsp_err   <= err_r;
          last          <= op_id;
          ovf_r         <= 1'b0;
          err_r         <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Directed and randomized bench for bcd_conv_sched with a behavioural converter
// and an arithmetic reference for arbitration order, BCD digits and latency.
module tb_bcd_conv_sched;
  localparam int N  = 4;
  localparam int TO = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  bcd_conv_sched_if #(.N_REQ(N)) bus ();
  bcd_conv_sched #(.N_REQ(N), .TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        stub_on = 1'b1;
  logic        stray_done = 1'b0;
  logic        model_done;
  logic [23:0] model_dout;
  logic        pend;
  int          cnt;
  logic [23:0] dval;

  assign bus.cv_done = model_done | stray_done;
  assign bus.cv_dout = model_dout;

  function automatic logic [23:0] to_bcd(input logic [31:0] v);
    logic [23:0] r;
    longint unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int pick(input logic [N-1:0] r, input int lst);
    for (int k = 1; k <= N; k++) if (r[(lst + k) % N]) return (lst + k) % N;
    return -1;
  endfunction

  // Converter: done 64 cycles after the cycle it sees cv_en.
  initial begin
    model_done = 1'b0;
    model_dout = '0;
    pend = 1'b0;
    cnt = 0;
    dval = '0;
    forever begin
      @(posedge clk);
      #1;
      model_done = 1'b0;
      if (!rst_n) pend = 1'b0;
      else begin
        if (pend) begin
          if (cnt == 0) begin
            model_done = stub_on;
            model_dout = dval;
            pend = 1'b0;
          end else cnt--;
        end
        if (bus.cv_en) begin
          pend = 1'b1;
          cnt = 63;
          dval = to_bcd(bus.cv_din);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  logic [31:0] vals [N];
  logic [N-1:0] hold_mask = '0;
  int last_m = N - 1;
  int en_count, en_first, ack_cyc;
  logic [31:0] en_din;
  int served[$];
  int acks[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] v);
    vals[i] = v;
    bus.req_din[32*i +: 32] = v;
    bus.req[i] = 1'b1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_m = N - 1;
  endtask

  task automatic run(input int nresp, input int budget);
    int got;
    int waited;
    got = 0;
    waited = 0;
    en_count = 0;
    en_first = -1;
    served.delete();
    acks.delete();
    while (got < nresp && waited < budget) begin
      step();
      waited++;
      if (bus.cv_en) begin
        en_count++;
        if (en_first < 0) begin
          en_first = cyc;
          en_din = bus.cv_din;
        end
      end
      if (bus.rsp_valid) begin
        int e;
        int ei;
        logic [31:0] v;
        logic [23:0] eb;
        logic eo, ee;
        logic [N-1:0] ea;
        e = pick(bus.req, last_m);
        ei = (e < 0) ? 0 : e;
        v = vals[ei];
        ea = '0;
        if (e >= 0) ea[ei] = 1'b1;
        if (v > 32'd999_999) begin eb = 24'h999999; eo = 1'b1; ee = 1'b0; end
        else if (!stub_on) begin eb = '0; eo = 1'b0; ee = 1'b1; end
        else begin eb = to_bcd(v); eo = 1'b0; ee = 1'b0; end
        chk("rsp_id", 32'(bus.rsp_id), 32'(e));
        chk("ack", 32'(bus.ack), 32'(ea));
        chk("rsp_bcd", 32'(bus.rsp_bcd), 32'(eb));
        chk("rsp_ovf", 32'(bus.rsp_ovf), 32'(eo));
        chk("rsp_err", 32'(bus.rsp_err), 32'(ee));
        served.push_back(int'(bus.rsp_id));
        acks.push_back(cyc);
        ack_cyc = cyc;
        last_m = ei;
        if (!hold_mask[ei]) bus.req[ei] = 1'b0;
        got++;
      end
    end
    chk("resp_count", 32'(got), 32'(nresp));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ack"}, 32'(bus.ack), 32'd0);
    chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_id"}, 32'(bus.rsp_id), 32'd0);
    chk({tag, "_bcd"}, 32'(bus.rsp_bcd), 32'd0);
    chk({tag, "_ovf"}, 32'(bus.rsp_ovf), 32'd0);
    chk({tag, "_err"}, 32'(bus.rsp_err), 32'd0);
    chk({tag, "_cv_en"}, 32'(bus.cv_en), 32'd0);
    chk({tag, "_cv_din"}, bus.cv_din, 32'd0);
  endtask

  initial begin
    int t;
    int seen;
    int got_en;
    logic [31:0] bnd [4];
    bus.req = '0;
    bus.req_din = '0;
    for (int i = 0; i < N; i++) vals[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single conversion
    step();
    t = cyc;
    set_req(0, 32'd1234);
    run(1, 100);
    chk("single_en_cycle", 32'(en_first), 32'(t + 1));
    chk("single_en_count", 32'(en_count), 32'd1);
    chk("single_cv_din", en_din, 32'd1234);
    chk("single_latency", 32'(ack_cyc), 32'(t + 67));

    // Arbitration from reset: all four at once
    reset_dut();
    step();
    set_req(0, 32'd1);
    set_req(1, 32'd22);
    set_req(2, 32'd333);
    set_req(3, 32'd4444);
    run(4, 400);
    for (int i = 0; i < 4 && i < served.size(); i++) chk("arb_order", 32'(served[i]), 32'(i));

    // Fairness: req0 and req2 held
    hold_mask = 4'b0101;
    set_req(0, $urandom_range(0, 999_999));
    set_req(2, $urandom_range(0, 999_999));
    run(6, 600);
    for (int i = 1; i < served.size(); i++) chk("fair_alt", 32'(served[i] != served[i-1]), 32'd1);
    bus.req = '0;
    hold_mask = '0;

    // Range boundaries on requester 0
    bnd[0] = 32'd999_999;
    bnd[1] = 32'd1_000_000;
    bnd[2] = 32'hFFFF_FFFF;
    bnd[3] = 32'd0;
    for (int i = 0; i < 4; i++) begin
      step();
      t = cyc;
      set_req(0, bnd[i]);
      run(1, 100);
      if (bnd[i] > 32'd999_999) begin
        chk("ovf_latency", 32'(ack_cyc), 32'(t + 2));
        chk("ovf_no_cv_en", 32'(en_count), 32'd0);
      end else begin
        chk("bnd_latency", 32'(ack_cyc), 32'(t + 67));
      end
    end

    // Back-to-back overflow from a held requester: 3-cycle ack spacing
    hold_mask = 4'b1000;
    set_req(3, 32'hFFFF_FFFF);
    run(2, 40);
    if (acks.size() == 2) chk("ovf_gap", 32'(acks[1] - acks[0]), 32'd3);
    bus.req = '0;
    hold_mask = '0;

    // Timeout, stray done, recovery
    stub_on = 1'b0;
    step();
    t = cyc;
    set_req(1, 32'd42);
    run(1, TO + 20);
    chk("to_latency", 32'(ack_cyc), 32'(t + 2 + TO));
    chk("to_en_count", 32'(en_count), 32'd1);
    repeat (5) step();
    stray_done = 1'b1;
    step();
    stray_done = 1'b0;
    seen = 0;
    repeat (10) begin
      step();
      if (bus.rsp_valid || bus.cv_en || (bus.ack != '0)) seen++;
    end
    chk("stray_ignored", 32'(seen), 32'd0);
    stub_on = 1'b1;
    step();
    t = cyc;
    set_req(2, $urandom_range(0, 999_999));
    run(1, 100);
    chk("recover_latency", 32'(ack_cyc), 32'(t + 67));

    // Randomized rounds
    for (int r = 0; r < 8; r++) begin
      int m;
      int n;
      m = $urandom_range(1, 15);
      n = 0;
      step();
      for (int i = 0; i < N; i++) begin
        if (m[i]) begin
          logic [31:0] v;
          case ($urandom_range(0, 3))
            0: v = $urandom_range(0, 999_999);
            1: v = $urandom;
            2: v = ($urandom_range(0, 1) == 1) ? 32'd999_999 : 32'd1_000_000;
            default: v = $urandom_range(0, 99);
          endcase
          set_req(i, v);
          n++;
        end
      end
      run(n, n * 80 + 20);
    end

    // Reset during WAIT
    step();
    set_req(1, 32'd77);
    got_en = 0;
    for (int i = 0; i < 5 && got_en == 0; i++) begin
      step();
      if (bus.cv_en) got_en = 1;
    end
    chk("rst_saw_cv_en", 32'(got_en), 32'd1);
    repeat (20) step();
    #3;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    last_m = N - 1;
    set_req(0, 32'd5);
    set_req(3, 32'd300);
    seen = 0;
    repeat (3) begin
      step();
      if (bus.rsp_valid || (bus.ack != '0)) seen++;
    end
    chk("midrst_no_ack", 32'(seen), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(3, 300);
    if (served.size() > 0) chk("post_rst_first", 32'(served[0]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_conv_sched.md
# bcd_conv_sched

Round-robin scheduler that shares one bin2bcd converter among N_REQ requesters in the seven-segment display path. It arbitrates, issues one conversion at a time, and handles display-range overflow without using the converter. It also guards against a stuck converter with a watchdog, then returns the 6-digit BCD result to the granted requester over a common response bus.

## Interface
- N_REQ, 4: number of requesters (2..8).
- TIMEOUT, 255: max cycles to wait in WAIT for cv_done before reporting an error (≥ 80).
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  N_REQ  level request per requester; held until its ack.
- req_din  in  32*N_REQ  binary value per requester; requester i uses bits [32i+31:32i]; stable while req[i] is high.
- ack  out  N_REQ  one-cycle pulse to the served requester.
- rsp_valid  out  1  one-cycle pulse, coincident with ack.
- rsp_id  out  3  index of the served requester; valid with rsp_valid.
- rsp_bcd  out  24  six BCD digits, MSD at [23:20]; valid with rsp_valid.
- rsp_ovf  out  1  input exceeded 999_999; valid with rsp_valid.
- rsp_err  out  1  converter timeout; valid with rsp_valid.
- cv_en  out  1  start pulse to the converter.
- cv_din  out  32  operand to the converter.
- cv_done  in  1  converter completion pulse.
- cv_dout  in  24  converter BCD result; sampled only in the cycle cv_done is high.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE, when any req bit is high:
  - Grant the first requester at or after (last+1) mod N_REQ.
  - Latch its id and din into op_id and op_din.
  - Evaluate overflow as op_din > 32'd999_999, unsigned.
  - If overflow: set bcd_r = 24'h999999 and ovf_r = 1, skip the converter, go to RESP.
  - Otherwise go to ISSUE.
- ISSUE: cv_en = 1 and cv_din = op_din for exactly one cycle; clear the timer; go to WAIT.
- WAIT: the timer increments each cycle.
  - If cv_done: bcd_r = cv_dout, go to RESP.
  - Else if timer == TIMEOUT-1: bcd_r = 0, err_r = 1, go to RESP.
  - If cv_done and timeout occur in the same cycle, cv_done wins and err_r stays 0.
- RESP:
  - Pulse rsp_valid and ack[op_id].
  - Drive rsp_bcd, rsp_ovf and rsp_err from the registers.
  - Set last = op_id, clear ovf_r and err_r, go to IDLE.
- A req still high in the cycle after its ack is treated as a new request. It is re-arbitrated, which gives other pending requesters priority first.
- Only one conversion is outstanding. cv_en is never asserted outside ISSUE.
- A cv_done outside WAIT is ignored. This covers a late done after a timeout.
- Reset values:
  - ack = 0, rsp_valid = 0, rsp_id = 0, rsp_bcd = 0, rsp_ovf = 0, rsp_err = 0.
  - cv_en = 0, cv_din = 0.
  - state = IDLE, timer = 0.
  - last = N_REQ-1, so requester 0 has top priority after reset.
- Reset mid-operation aborts immediately to the reset values. The converter shares rst_n, so no partial response is ever emitted.

## Timing
- Req high at cycle t in IDLE:
  - cv_en is high at t+1.
  - The converter samples it at the end of t+1.
- The converter asserts done nominally 64 cycles after sampling en: 32 shift/add3 pairs. The scheduler must not depend on this value.
- rsp_valid/ack occur in the cycle after cv_done is seen: nominally t+67.
- Overflow path: rsp_valid at t+2.
- Timeout path: rsp_valid at t+2+TIMEOUT.
- Back-to-back: next arbitration at the cycle after RESP. The minimum gap between ack pulses is 3 cycles (overflow path).

## Test plan
- Single conversion: req[0] with 1234 at t.
  - cv_en only at t+1, cv_din = 1234.
  - Behavioural converter: rsp_valid and ack[0] together at t+67, rsp_bcd = 24'h001234.
  - rsp_id = 0, rsp_ovf = 0, rsp_err = 0.
- Arbitration: all four req rise in the same cycle with values 1, 22, 333, 4444, each dropped after its ack.
  - Served in order 0,1,2,3.
  - rsp_bcd = 24'h000001, 24'h000022, 24'h000333, 24'h004444.
- Fairness: req0 and req2 held high continuously.
  - ack sequence 0,2,0,2,…
  - Neither requester is served twice in a row while the other is pending.
- Range boundaries, issued in turn:
  - 999_999: conversion, 24'h999999, rsp_ovf = 0.
  - 1_000_000: no cv_en, 24'h999999, rsp_ovf = 1, rsp_valid 2 cycles after req.
  - 0xFFFF_FFFF: same as 1_000_000.
  - 0: 24'h000000.
- Timeout: converter stub never asserts done, req[1] with 42.
  - rsp_err = 1, rsp_bcd = 0, ack[1] at t+2+TIMEOUT.
  - A stray cv_done injected 5 cycles later is ignored.
  - The next request completes normally.
- Reset mid-WAIT: deassert rst_n 20 cycles after cv_en.
  - All outputs return to 0 asynchronously, with no ack.
  - After release, requester 0 is served first.
